// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch sequencer.
//   PC_W          : PC / redirect address width used by the fetch queue entries
//   INSTR_W       : instruction word width
//   PC_STEP       : byte increment between sequential instruction words
//   fetch_entry_t : one queued {pc, instr} pair
//   fetch_state_e : fetch FSM states (HALT is reachable only with FETCH_HALT_EN)
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
// Bundles the imem port, the redirect request and the decode-side queue head.
//   master : the fetch controller (drives imem_addr, out_*, halted)
//   slave  : imem + datapath + decode side (drives imem_q, redirect_*, out_ready)
// -----------------------------------------------------------------------------
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int N       = PC_W,
    parameter int IMEM_AW = 6
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_q;
    logic               redirect_valid;
    logic [N-1:0]       redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [N-1:0]       out_pc;
    logic               halted;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, halted,
        input  imem_q, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, halted,
        output imem_q, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry in-order circular queue of fetch_entry_t.
//   clk, srst : clock, synchronous active-high reset
//   push      : enqueue wr_data (ignored when full)
//   wr_data   : entry to enqueue
//   pop       : dequeue head (ignored when empty)
//   flush     : drop every entry this cycle (wins over push/pop)
//   full      : count == DEPTH
//   empty     : count == 0
//   head      : oldest entry, valid when !empty
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         push,
    input  fetch_entry_t wr_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_reg [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];

    // Storage is not reset: entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer: owns the PC, addresses the combinational imem,
// buffers {pc, instr} pairs for decode and applies branch redirects.
//   clk    : single clock, all state on the rising edge
//   reset  : synchronous, active-high
//   bus    : fetch_if.master (imem_addr/imem_q, redirect_valid/redirect_pc,
//            out_valid/out_ready/out_instr/out_pc, halted)
// Optional feature macro: FETCH_HALT_EN
//   defined   : fetching a zero word stops fetch (HALT) until redirect/reset;
//               halted = HALT && queue empty
//   undefined : zero words are ordinary instructions; halted tied to 0
// N must equal fetch_pkg::PC_W, which sizes the queue entries.
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int           N        = PC_W,
    parameter int           IMEM_AW  = 6,
    parameter int           DEPTH    = 2,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);
    fetch_state_e state_reg;
    fetch_state_e state_next;
    logic [N-1:0] pc_reg;
    logic [N-1:0] pc_next;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    logic         fetch_ok;
    fetch_entry_t head;
    fetch_entry_t wr_data;

    // Eligible to fetch this cycle; a full queue blocks even if a pop is
    // happening, so the decision never depends on out_ready.
    assign fetch_ok = (state_reg == RUN) && !full && !bus.redirect_valid;
    // A redirect cycle discards the head, so it is not a real handoff.
    assign pop      = !empty && bus.out_ready && !bus.redirect_valid;
    assign wr_data  = '{pc: pc_reg, instr: bus.imem_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        push       = fetch_ok;
`ifdef FETCH_HALT_EN
        // A zero word is a stop marker: not queued, PC stays on it.
        if (fetch_ok && (bus.imem_q == '0)) begin
            push       = 1'b0;
            state_next = HALT;
        end
`endif
        if (push) begin
            pc_next = pc_reg + N'(PC_STEP);
        end
        if (bus.redirect_valid) begin
            pc_next    = bus.redirect_pc & ~N'(3);
            state_next = RUN;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .srst    (reset),
        .push    (push),
        .wr_data (wr_data),
        .pop     (pop),
        .flush   (bus.redirect_valid),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    // Only the word-index bits reach the ROM; higher PCs alias.
    assign bus.imem_addr = pc_reg[IMEM_AW+1:2];
    assign bus.out_valid = !empty;
    assign bus.out_instr = empty ? '0 : head.instr;
    assign bus.out_pc    = empty ? '0 : head.pc;

`ifdef FETCH_HALT_EN
    assign bus.halted = (state_reg == HALT) && empty;
`else
    assign bus.halted = 1'b0;
`endif

endmodule
